// File: rtl/object_collision_checker_pkg.sv
// Shared record layout for the object table: field positions, widths and type codes.
// The object table, player updater and collision checker all unpack records through here.
package object_collision_checker_pkg;

    localparam int DATALEN = 38;
    localparam int TYPELEN = 2;
    localparam int XYLEN   = 10;
    localparam int WHLEN   = 8;
    localparam int NUM_OBJ = 8;
    localparam int IDXLEN  = 3;
    localparam int TIMEOUT = 15;
    localparam int WCNTLEN = $clog2(TIMEOUT);

    localparam int TYPE_LSB = 0;
    localparam int X_LSB    = 2;
    localparam int Y_LSB    = 12;
    localparam int W_LSB    = 22;
    localparam int H_LSB    = 30;

    localparam logic [TYPELEN-1:0] TYPE_EMPTY  = 2'd0;
    localparam logic [TYPELEN-1:0] TYPE_PLAYER = 2'd3;

    typedef struct packed {
        logic [XYLEN-1:0] x;
        logic [XYLEN-1:0] y;
        logic [WHLEN-1:0] w;
        logic [WHLEN-1:0] h;
    } box_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CMP,
        S_DONE
    } state_t;

    function automatic box_t rec_to_box(input logic [DATALEN-1:0] rec);
        box_t b;
        b.x = rec[X_LSB +: XYLEN];
        b.y = rec[Y_LSB +: XYLEN];
        b.w = rec[W_LSB +: WHLEN];
        b.h = rec[H_LSB +: WHLEN];
        return b;
    endfunction

    function automatic logic [TYPELEN-1:0] rec_type(input logic [DATALEN-1:0] rec);
        return rec[TYPE_LSB +: TYPELEN];
    endfunction

endpackage

// File: rtl/object_collision_checker_overlap.sv
// Combinational axis-aligned bounding-box overlap between two boxes.
// Edges that merely touch do not overlap, and a zero-sized box never overlaps anything.
module aabb_overlap
    import object_collision_checker_pkg::*;
(
    input  box_t a_i,
    input  box_t b_i,
    output logic overlap_o
);
    localparam int PAD = XYLEN + 1 - WHLEN;

    // Far edges carry one extra bit so x+w never wraps at the screen edge.
    logic [XYLEN:0] a_x0, a_y0, b_x0, b_y0;
    logic [XYLEN:0] a_x1, a_y1, b_x1, b_y1;
    logic           nonzero;

    assign a_x0 = {1'b0, a_i.x};
    assign a_y0 = {1'b0, a_i.y};
    assign b_x0 = {1'b0, b_i.x};
    assign b_y0 = {1'b0, b_i.y};

    assign a_x1 = a_x0 + {{PAD{1'b0}}, a_i.w};
    assign a_y1 = a_y0 + {{PAD{1'b0}}, a_i.h};
    assign b_x1 = b_x0 + {{PAD{1'b0}}, b_i.w};
    assign b_y1 = b_y0 + {{PAD{1'b0}}, b_i.h};

    assign nonzero = (a_i.w != '0) && (a_i.h != '0) && (b_i.w != '0) && (b_i.h != '0);

    assign overlap_o = nonzero
                     && (a_x0 < b_x1) && (b_x0 < a_x1)
                     && (a_y0 < b_y1) && (b_y0 < a_y1);

endmodule

// File: rtl/object_collision_checker.sv
// Per-tick scanner: latches the player, reads each obstacle slot in turn and reports
// whether any overlaps the player, the first overlapping slot, and read timeouts.
module object_collision_checker
    import object_collision_checker_pkg::*;
(
    input  logic               clk3,
    input  logic               reset,
    input  logic               pause,
    input  logic               scan_start,
    input  logic [DATALEN-1:0] player,
    output logic               obj_rd,
    output logic [IDXLEN-1:0]  obj_addr,
    input  logic               obj_valid,
    input  logic [DATALEN-1:0] obj_data,
    output logic               busy,
    output logic               scan_done,
    output logic               hit,
    output logic [IDXLEN-1:0]  hit_idx,
    output logic               rd_err
);
    localparam logic [IDXLEN-1:0]  LAST_SLOT = IDXLEN'(NUM_OBJ - 1);
    localparam logic [WCNTLEN-1:0] WAIT_LAST = WCNTLEN'(TIMEOUT - 1);

    state_t             state_q;
    logic [DATALEN-1:0] player_q;
    logic [DATALEN-1:0] obj_q;
    logic [IDXLEN-1:0]  slot_q;
    logic [IDXLEN-1:0]  slot_d;
    logic [IDXLEN-1:0]  first_idx_q;
    logic [IDXLEN-1:0]  hit_idx_q;
    logic [WCNTLEN-1:0] wait_cnt_q;
    logic               acc_q;
    logic               obj_rd_q;
    logic               busy_q;
    logic               scan_done_q;
    logic               hit_q;
    logic               rd_err_q;

    box_t player_box;
    box_t obj_box;
    logic overlap;
    logic obj_hit;
    logic last_slot;

    assign player_box = rec_to_box(player_q);
    assign obj_box    = rec_to_box(obj_q);

    aabb_overlap u_overlap (
        .a_i       (player_box),
        .b_i       (obj_box),
        .overlap_o (overlap)
    );

    assign obj_hit   = (rec_type(obj_q) != TYPE_EMPTY) && overlap;
    assign last_slot = (slot_q == LAST_SLOT);
    assign slot_d    = slot_q + IDXLEN'(1);

    always_ff @(posedge clk3 or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            player_q    <= '0;
            obj_q       <= '0;
            slot_q      <= '0;
            first_idx_q <= '0;
            hit_idx_q   <= '0;
            wait_cnt_q  <= '0;
            acc_q       <= 1'b0;
            obj_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
            scan_done_q <= 1'b0;
            hit_q       <= 1'b0;
            rd_err_q    <= 1'b0;
        end else if (pause) begin
            obj_rd_q    <= 1'b0;
            scan_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (scan_start) begin
                        player_q <= player;
                        acc_q    <= 1'b0;
                        slot_q   <= '0;
                        busy_q   <= 1'b1;
                        obj_rd_q <= 1'b1;
                        state_q  <= S_REQ;
                    end
                end
                S_REQ: begin
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (obj_valid) begin
                        obj_q   <= obj_data;
                        state_q <= S_CMP;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        // Unanswered slot is scored as a miss; move on exactly as CMP would.
                        rd_err_q <= 1'b1;
                        if (last_slot) begin
                            state_q <= S_DONE;
                        end else begin
                            slot_q   <= slot_d;
                            obj_rd_q <= 1'b1;
                            state_q  <= S_REQ;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WCNTLEN'(1);
                    end
                end
                S_CMP: begin
                    if (obj_hit) begin
                        acc_q <= 1'b1;
                        if (!acc_q) begin
                            first_idx_q <= slot_q;
                        end
                    end
                    if (last_slot) begin
                        state_q <= S_DONE;
                    end else begin
                        slot_q   <= slot_d;
                        obj_rd_q <= 1'b1;
                        state_q  <= S_REQ;
                    end
                end
                S_DONE: begin
                    hit_q <= acc_q;
                    if (acc_q) begin
                        hit_idx_q <= first_idx_q;
                    end
                    scan_done_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign obj_rd    = obj_rd_q;
    assign obj_addr  = slot_q;
    assign busy      = busy_q;
    assign scan_done = scan_done_q;
    assign hit       = hit_q;
    assign hit_idx   = hit_idx_q;
    assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_object_collision_checker.sv
// Bench for object_collision_checker: an object-table responder with per-slot latency,
// directed scenarios and randomized scans compared against a box-arithmetic reference model.
module tb_object_collision_checker;

    localparam int NUM_OBJ = 8;
    localparam int TIMEOUT = 15;

    logic        clk3       = 1'b0;
    logic        reset      = 1'b0;
    logic        pause      = 1'b1;
    logic        scan_start = 1'b0;
    logic [37:0] player     = '0;
    logic        obj_rd;
    logic [2:0]  obj_addr;
    logic        obj_valid  = 1'b0;
    logic [37:0] obj_data   = '0;
    logic        busy;
    logic        scan_done;
    logic        hit;
    logic [2:0]  hit_idx;
    logic        rd_err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [37:0] obj_tbl [NUM_OBJ];
    int          dly     [NUM_OBJ];   // response latency per slot, 0 = never answers
    bit          exp_hit = 1'b0;
    int          exp_idx = 0;
    bit          exp_err = 1'b0;

    always #5 clk3 = ~clk3;

    object_collision_checker dut (
        .clk3       (clk3),
        .reset      (reset),
        .pause      (pause),
        .scan_start (scan_start),
        .player     (player),
        .obj_rd     (obj_rd),
        .obj_addr   (obj_addr),
        .obj_valid  (obj_valid),
        .obj_data   (obj_data),
        .busy       (busy),
        .scan_done  (scan_done),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .rd_err     (rd_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] rec(input int t, input int x, input int y, input int w, input int h);
        return {8'(h), 8'(w), 10'(y), 10'(x), 2'(t)};
    endfunction

    // Reference: plain integer rectangle intersection, no wrap possible.
    function automatic bit model_hit(input logic [37:0] p, input logic [37:0] o);
        int px, py, pw, ph, ot, ox, oy, ow, oh;
        px = int'(p[11:2]);  py = int'(p[21:12]); pw = int'(p[29:22]); ph = int'(p[37:30]);
        ot = int'(o[1:0]);
        ox = int'(o[11:2]);  oy = int'(o[21:12]); ow = int'(o[29:22]); oh = int'(o[37:30]);
        if (ot == 0 || pw == 0 || ph == 0 || ow == 0 || oh == 0) return 1'b0;
        return (px < ox + ow) && (ox < px + pw) && (py < oy + oh) && (oy < py + ph);
    endfunction

    function automatic logic [37:0] junk();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[37:0];
    endfunction

    // Object-table responder: answers a read d cycles after the strobe with one valid cycle.
    initial begin
        forever begin
            @(posedge clk3); #1;
            if (obj_rd && !reset) begin
                int a;
                int d;
                a = int'(obj_addr);
                d = dly[a];
                if (d > 0) begin
                    repeat (d) @(posedge clk3);
                    #1;
                    obj_valid = 1'b1;
                    obj_data  = obj_tbl[a];
                    @(posedge clk3); #1;
                    obj_valid = 1'b0;
                    obj_data  = junk();
                end
            end
        end
    end

    task automatic clear_table();
        for (int s = 0; s < NUM_OBJ; s++) begin
            obj_tbl[s] = rec(0, $urandom_range(0, 200), $urandom_range(0, 200), 30, 30);
            dly[s]     = 1;
        end
    endtask

    task automatic do_scan(input string name, input logic [37:0] pl, input int pause_slot, input bit restart);
        bit h;
        int first;
        int lat;
        int k;
        int done_k;
        int done_n;
        int req_k;
        h     = 1'b0;
        first = 0;
        lat   = 1;
        for (int s = 0; s < NUM_OBJ; s++) begin
            if (dly[s] == 0) begin
                lat += 1 + TIMEOUT;
                exp_err = 1'b1;
            end else begin
                lat += dly[s] + 2;
                if (model_hit(pl, obj_tbl[s])) begin
                    if (!h) first = s;
                    h = 1'b1;
                end
            end
        end
        if (pause_slot >= 0) lat += 10;
        exp_hit = h;
        if (h) exp_idx = first;

        player     = pl;
        scan_start = 1'b1;
        @(posedge clk3); #1;
        scan_start = 1'b0;
        chk({name, ".busy_start"}, 64'(busy), 64'(1));

        done_k = -1;
        done_n = 0;
        req_k  = -1;
        k      = 0;
        while (k < lat + 8) begin
            @(posedge clk3); #1;
            k++;
            if (scan_done) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (restart && k == 4) begin
                scan_start = 1'b1;
                player     = ~pl;
            end
            if (restart && k == 5) scan_start = 1'b0;
            if (pause_slot >= 0 && req_k < 0 && obj_rd && int'(obj_addr) == pause_slot) req_k = k;
            if (req_k >= 0 && k == req_k + 2) begin
                pause = 1'b0;
                repeat (10) begin
                    @(posedge clk3); #1;
                    k++;
                end
                chk({name, ".pause_addr"}, 64'(obj_addr), 64'(pause_slot));
                chk({name, ".pause_busy"}, 64'(busy), 64'(1));
                pause = 1'b1;
            end
        end
        chk({name, ".latency"}, 64'(done_k), 64'(lat));
        chk({name, ".done_pulses"}, 64'(done_n), 64'(1));
        chk({name, ".hit"}, 64'(hit), 64'(exp_hit));
        chk({name, ".hit_idx"}, 64'(hit_idx), 64'(exp_idx));
        chk({name, ".rd_err"}, 64'(rd_err), 64'(exp_err));
        chk({name, ".busy_end"}, 64'(busy), 64'(0));
        $display("[TB] scan %s: latency=%0d hit=%0d hit_idx=%0d rd_err=%0d", name, done_k, hit, hit_idx, rd_err);
    endtask

    task automatic reset_mid_scan(input logic [37:0] pl);
        int  k;
        bit  seen;
        int  done_n;
        player     = pl;
        scan_start = 1'b1;
        @(posedge clk3); #1;
        scan_start = 1'b0;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 200) begin
            @(posedge clk3); #1;
            k++;
            if (obj_rd && obj_addr == 3'd5) seen = 1'b1;
        end
        chk("rst.reach_slot5", 64'(seen), 64'(1));
        #2 reset = 1'b1;
        #1;
        chk("rst.outputs", 64'({obj_rd, obj_addr, busy, scan_done, hit, hit_idx, rd_err}), 64'(0));
        exp_hit = 1'b0;
        exp_idx = 0;
        exp_err = 1'b0;
        @(posedge clk3); #1;
        reset  = 1'b0;
        done_n = 0;
        repeat (40) begin
            @(posedge clk3); #1;
            if (scan_done) done_n++;
        end
        chk("rst.no_done", 64'(done_n), 64'(0));
        chk("rst.idle_busy", 64'(busy), 64'(0));
        $display("[TB] reset mid-scan at slot 5: scan_done pulses afterwards=%0d", done_n);
    endtask

    initial begin
        logic [37:0] p;
        logic [37:0] rp;

        #1 reset = 1'b1;
        repeat (2) @(posedge clk3);
        #1;
        chk("reset.outputs", 64'({obj_rd, obj_addr, busy, scan_done, hit, hit_idx, rd_err}), 64'(0));
        reset = 1'b0;
        repeat (2) @(posedge clk3);
        #1;

        p = rec(3, 40, 100, 20, 20);

        clear_table();
        obj_tbl[3] = rec(1, 50, 110, 10, 10);
        do_scan("single_hit", p, -1, 1'b0);

        clear_table();
        obj_tbl[2] = rec(1, 60, 110, 10, 10);
        do_scan("edge_touch", p, -1, 1'b0);

        clear_table();
        obj_tbl[1] = rec(2, 45, 105, 5, 5);
        obj_tbl[5] = rec(1, 30, 90, 15, 15);
        do_scan("two_hits", p, -1, 1'b0);

        clear_table();
        obj_tbl[3] = rec(1, 50, 110, 10, 10);
        dly[4]     = 0;
        do_scan("timeout", p, -1, 1'b0);

        clear_table();
        obj_tbl[1] = rec(2, 45, 105, 5, 5);
        obj_tbl[5] = rec(1, 30, 90, 15, 15);
        for (int s = 0; s < NUM_OBJ; s++) dly[s] = $urandom_range(1, 3);
        do_scan("restart_ignored", p, -1, 1'b1);

        clear_table();
        obj_tbl[3] = rec(1, 50, 110, 10, 10);
        dly[4]     = 0;
        do_scan("pause", p, 4, 1'b0);

        clear_table();
        obj_tbl[6] = rec(1, 50, 110, 10, 10);
        reset_mid_scan(p);

        for (int t = 0; t < 20; t++) begin
            rp = rec(3, $urandom_range(0, 200), $urandom_range(0, 200),
                     ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 60),
                     ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 60));
            for (int s = 0; s < NUM_OBJ; s++) begin
                obj_tbl[s] = rec($urandom_range(0, 3), $urandom_range(0, 200), $urandom_range(0, 200),
                                 ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 60),
                                 ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 60));
                dly[s] = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, TIMEOUT);
            end
            do_scan($sformatf("rand%0d", t), rp, -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/object_collision_checker.md
Name: object_collision_checker

Overview:
- Consumer and reader side of the packed object-record interface: latches the player record, reads every obstacle record from the object table slot by slot, and tests each against the player with an axis-aligned bounding-box test.
- Runs one full scan per game tick.
- Reports hit, the first hit slot, scan completion and a read-timeout error to the game-control FSM, which uses them to end the game.

Parameters:
- DATALEN, 38, total record width: type[1:0], x[11:2], y[21:12], width[29:22], height[37:30].
- TYPELEN, 2, object type field width; type 0 = empty slot.
- XYLEN, 10, x/y field width (pixels).
- WHLEN, 8, width/height field width (pixels).
- NUM_OBJ, 8, obstacle slots in the object table.
- IDXLEN, 3, slot index width, equal to clog2(NUM_OBJ).
- TIMEOUT, 15, maximum wait cycles for obj_valid per slot.

Ports:
- clk3  in  1  game clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- pause  in  1  active-low freeze; while 0 all state and outputs hold.
- scan_start  in  1  one-cycle pulse requesting a scan (game tick).
- player  in  DATALEN  packed player record; sampled on scan_start.
- obj_rd  out  1  read strobe to object table, one cycle per request.
- obj_addr  out  IDXLEN  slot being read.
- obj_valid  in  1  read data valid, 1..TIMEOUT cycles after obj_rd.
- obj_data  in  DATALEN  packed obstacle record.
- busy  out  1  scan in progress.
- scan_done  out  1  one-cycle pulse when a scan completes.
- hit  out  1  result of the last completed scan.
- hit_idx  out  IDXLEN  lowest-numbered slot that hit in the last scan.
- rd_err  out  1  sticky; set on any read timeout, cleared only by reset.

Behaviour:
- Reset values: obj_rd=0, obj_addr=0, busy=0, scan_done=0, hit=0, hit_idx=0, rd_err=0; FSM enters IDLE.
- Reset mid-scan aborts the scan with no scan_done pulse.
- FSM states: IDLE, REQ, WAIT, CMP, DONE.
  - IDLE: on scan_start, latch the player record, clear the internal hit accumulator, slot=0, busy=1, go to REQ.
  - REQ: obj_rd=1 for exactly one cycle with obj_addr=slot; clear the wait counter; go to WAIT.
  - WAIT: if obj_valid, register obj_data and go to CMP. Otherwise increment the wait counter. On reaching TIMEOUT, set rd_err, treat the slot as a miss, and advance as CMP would.
  - CMP: if type≠0 and the boxes overlap, set the accumulator; record slot in hit_idx only if it is the first hit this scan. If slot==NUM_OBJ-1 go to DONE, else slot+1 and go to REQ.
  - DONE: hit<=accumulator; hit_idx updates only if a hit occurred; scan_done=1 for one cycle; busy=0; go to IDLE.
- Overlap test, strict inequalities, sums computed in XYLEN+1 bits (no wrap): px < ox+ow AND ox < px+pw AND py < oy+oh AND oy < py+ph. Edge-touching boxes do not collide.
- A width or height of 0 never collides.
- scan_start while busy is ignored; the player record is not re-latched.
- obj_valid outside WAIT is ignored.
- hit and hit_idx hold between scans and change only in DONE.
- Latency: a scan with all reads answered in 1 cycle takes 3·NUM_OBJ+1 cycles from scan_start to scan_done.
- pause=0 freezes the FSM, counters and outputs. An obj_valid arriving during pause is lost, and the timeout resumes counting after unpause.
- The slot counter stops at NUM_OBJ-1 and never wraps within a scan.

Decomposition:
- Shared package/define file: field start/length constants, DATALEN, the empty-type code, and the player type code.
  - The object table and player updater use the same constants.
- One sub-module: aabb_overlap, combinational, taking two unpacked boxes and producing the overlap bit.
  - Instantiated once and reused by a future renderer.

Test Plan:
- Player x=40,y=100,w=20,h=20; slot 3 type=1 x=50,y=110,w=10,h=10; all other slots type 0; 1-cycle responder -> scan_done at cycle 25, hit=1, hit_idx=3, rd_err=0.
- Same player; slot 2 at x=60 (edge-touching) -> hit=0, hit_idx unchanged from the previous scan.
- Slots 1 and 5 both overlapping -> hit=1, hit_idx=1.
- Responder never answers slot 4 -> WAIT lasts 15 cycles; rd_err=1; slot 4 counted as miss; scan completes with scan_done pulse.
- scan_start repeated mid-scan with a different player record -> ignored; result uses the first record; exactly one scan_done.
- reset asserted at slot 5 -> all outputs 0 immediately, no scan_done. Pause held for 10 cycles mid-WAIT -> obj_addr and busy hold, completion delayed by 10 cycles.
